// File: rtl/waffle_memio.sv
// WAFFLE memory/IO subsystem: RAM, IN/OUT channels and an edge-triggered IRQ block.
// Optional access checking is built when WAFFLE_MEMIO_BOUNDS_EN is defined.
module waffle_memio #(
  parameter int    DATA_W        = 8,
  parameter int    ADDR_W        = 16,
  parameter int    RAM_DEPTH     = 900,
  parameter string INIT_FILE     = "",
  parameter int    WAIT_STATES   = 0,
  parameter int    NUM_IN        = 1,
  parameter int    IN_BASE       = 998,
  parameter int    NUM_OUT       = 1,
  parameter int    OUT_BASE      = 999,
  parameter int    IRQ_N         = 4,
  parameter int    IRQ_PEND_ADDR = 1000,
  parameter int    IRQ_MASK_ADDR = 1001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic                      ready,
  output logic                      ack,
  output logic [DATA_W-1:0]         rdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_ports,
  output logic [NUM_OUT*DATA_W-1:0] out_ports,
  input  logic [IRQ_N-1:0]          irq_lines,
  output logic                      irq,
  output logic                      err
);

  localparam int AW1 = ADDR_W + 1;
  localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [ADDR_W:0] L_RAM_END = AW1'(RAM_DEPTH);
  localparam logic [ADDR_W:0] L_IN_LO   = AW1'(IN_BASE);
  localparam logic [ADDR_W:0] L_IN_HI   = AW1'(IN_BASE + NUM_IN);
  localparam logic [ADDR_W:0] L_OUT_LO  = AW1'(OUT_BASE);
  localparam logic [ADDR_W:0] L_OUT_HI  = AW1'(OUT_BASE + NUM_OUT);
  localparam logic [ADDR_W:0] L_PEND    = AW1'(IRQ_PEND_ADDR);
  localparam logic [ADDR_W:0] L_MASK    = AW1'(IRQ_MASK_ADDR);

  function automatic bit ovl(int alo, int an, int blo, int bn);
    return (alo < blo + bn) && (blo < alo + an);
  endfunction

  localparam bit L_BAD =
    ovl(0, RAM_DEPTH, IN_BASE, NUM_IN) ||
    ovl(0, RAM_DEPTH, OUT_BASE, NUM_OUT) ||
    ovl(0, RAM_DEPTH, IRQ_PEND_ADDR, 1) ||
    ovl(0, RAM_DEPTH, IRQ_MASK_ADDR, 1) ||
    ovl(IN_BASE, NUM_IN, OUT_BASE, NUM_OUT) ||
    ovl(IN_BASE, NUM_IN, IRQ_PEND_ADDR, 1) ||
    ovl(IN_BASE, NUM_IN, IRQ_MASK_ADDR, 1) ||
    ovl(OUT_BASE, NUM_OUT, IRQ_PEND_ADDR, 1) ||
    ovl(OUT_BASE, NUM_OUT, IRQ_MASK_ADDR, 1) ||
    ovl(IRQ_PEND_ADDR, 1, IRQ_MASK_ADDR, 1) ||
    (WAIT_STATES < 0) || (WAIT_STATES > 15) ||
    (IRQ_N < 1) || (IRQ_N > DATA_W);

  if (L_BAD) begin : g_bad_params
    $error("waffle_memio: overlapping regions or illegal parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0]         r_mem [0:RAM_DEPTH-1];
  logic [DATA_W-1:0]         r_ram_q;
  logic [NUM_IN*DATA_W-1:0]  r_in_q;
  logic [NUM_OUT*DATA_W-1:0] r_out;
  logic [IRQ_N-1:0]          r_pend;
  logic [IRQ_N-1:0]          r_mask;
  logic                      r_irq;
  logic [IRQ_N-1:0]          r_s1;
  logic [IRQ_N-1:0]          r_s2;
  logic [IRQ_N-1:0]          r_s3;

  logic [ADDR_W:0]   w_a;
  logic [ADDR_W-1:0] w_ra;
  logic              w_resp;
  logic              w_wr;
  logic              w_rd;
  logic              w_rsvd;
  logic              w_hit_ram;
  logic              w_hit_in;
  logic              w_hit_out;
  logic              w_hit_pend;
  logic              w_hit_mask;
  logic [DATA_W-1:0] w_in_sel;
  logic [DATA_W-1:0] w_out_sel;
  logic [NUM_OUT-1:0] w_out_wr;
  logic [IRQ_N-1:0]  w_clr;
  logic [IRQ_N-1:0]  w_edge;
  logic [DATA_W-1:0] w_pend_x;
  logic [DATA_W-1:0] w_mask_x;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    ready      = 1'b0;
    ack        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready      = 1'b1;
        w_cnt_next = 4'(WAIT_STATES);
        if (req) begin
          w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        ack    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (ready && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
    end
  end

  assign w_resp = (r_state == S_RESP);
  assign w_wr   = w_resp && r_we && !rst;
  assign w_rd   = w_resp && !r_we;
  assign w_a    = {1'b0, r_addr};

`ifdef WAFFLE_MEMIO_BOUNDS_EN
  assign w_rsvd = !(w_a < L_RAM_END) && (&r_addr);
`else
  assign w_rsvd = 1'b0;
`endif

  assign w_hit_ram  = (w_a < L_RAM_END);
  assign w_hit_in   = !w_hit_ram && !w_rsvd &&
                      (w_a >= L_IN_LO) && (w_a < L_IN_HI);
  assign w_hit_out  = !w_hit_ram && !w_hit_in && !w_rsvd &&
                      (w_a >= L_OUT_LO) && (w_a < L_OUT_HI);
  assign w_hit_pend = !w_hit_ram && !w_hit_in && !w_hit_out &&
                      !w_rsvd && (w_a == L_PEND);
  assign w_hit_mask = !w_hit_ram && !w_hit_in && !w_hit_out &&
                      !w_hit_pend && !w_rsvd && (w_a == L_MASK);

  always_comb begin
    w_in_sel  = '0;
    w_out_sel = '0;
    w_out_wr  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_a == AW1'(IN_BASE + k)) begin
        w_in_sel = r_in_q[k*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_a == AW1'(OUT_BASE + k)) begin
        w_out_sel   = r_out[k*DATA_W +: DATA_W];
        w_out_wr[k] = w_wr && w_hit_out;
      end
    end
  end

  // Read port runs every cycle; in IDLE it tracks the incoming address
  // so a zero-wait transaction still sees registered data in RESP.
  assign w_ra = (r_state == S_IDLE) ? addr : r_addr;

  always_ff @(posedge clk) begin
    if (w_wr && w_hit_ram) begin
      r_mem[r_addr[RAW-1:0]] <= r_wdata;
    end
    r_ram_q <= r_mem[w_ra[RAW-1:0]];
    r_in_q  <= in_ports;
  end

  assign w_edge = r_s2 & ~r_s3;
  assign w_clr  = (w_wr && w_hit_pend) ? r_wdata[IRQ_N-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
    end else begin
      r_s1   <= irq_lines;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_irq  <= |(r_pend & r_mask);
      if (w_wr && w_hit_mask) begin
        r_mask <= r_wdata[IRQ_N-1:0];
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_out_wr[k]) begin
          r_out[k*DATA_W +: DATA_W] <= r_wdata;
        end
      end
    end
  end

  always_comb begin
    w_pend_x              = '0;
    w_mask_x              = '0;
    w_pend_x[IRQ_N-1:0]   = r_pend;
    w_mask_x[IRQ_N-1:0]   = r_mask;
    rdata                 = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_hit_ram:  rdata = r_ram_q;
        w_hit_in:   rdata = w_in_sel;
        w_hit_out:  rdata = w_out_sel;
        w_hit_pend: rdata = w_pend_x;
        w_hit_mask: rdata = w_mask_x;
        default:    rdata = '0;
      endcase
    end
  end

  assign out_ports = r_out;
  assign irq       = r_irq;

`ifdef WAFFLE_MEMIO_BOUNDS_EN
  logic r_err;
  logic w_bad;

  assign w_bad = w_resp && !rst && (
                   !(w_hit_ram || w_hit_in || w_hit_out ||
                     w_hit_pend || w_hit_mask) ||
                   (r_we && w_hit_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end

  // Visible during the offending RESP cycle and sticky afterwards.
  assign err = r_err || w_bad;
`else
  assign err = 1'b0;
`endif

endmodule
